// File: rtl/excp_irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// excp_irq_ctrl_pkg
// Shared definitions for the interrupt/exception trap controller:
//   - 2-bit FSM state encoding
//   - machine interrupt cause codes (MEI/MSI/MTI)
//   - mtvec mode encodings
// -----------------------------------------------------------------------------
package excp_irq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_TRAP_CSR   = 2'd1,
      ST_REDIR      = 2'd2,
      ST_MRET_REDIR = 2'd3
   } excp_state_e;

   localparam int unsigned CAUSE_MEI = 11;
   localparam int unsigned CAUSE_MSI = 3;
   localparam int unsigned CAUSE_MTI = 7;

   localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/excp_irq_ctrl_irq_prio_enc.sv
// -----------------------------------------------------------------------------
// excp_irq_ctrl_irq_prio_enc
// Combinational enable gating and fixed-priority encoder for the three machine
// interrupt sources. Priority: external > software > timer.
// Ports:
//   ext_i/sft_i/tmr_i     pending indicators from intagent
//   meie_i/msie_i/mtie_i  per-source enables (mie)
//   mie_global_i          mstatus.MIE
//   any_irq_o             at least one enabled interrupt pending
//   code_o                cause code of the winning source (0 when none)
// -----------------------------------------------------------------------------
module excp_irq_ctrl_irq_prio_enc #(
   parameter int unsigned CODE_MEI = excp_irq_ctrl_pkg::CAUSE_MEI,
   parameter int unsigned CODE_MSI = excp_irq_ctrl_pkg::CAUSE_MSI,
   parameter int unsigned CODE_MTI = excp_irq_ctrl_pkg::CAUSE_MTI
) (
   input  logic       ext_i,
   input  logic       sft_i,
   input  logic       tmr_i,
   input  logic       meie_i,
   input  logic       msie_i,
   input  logic       mtie_i,
   input  logic       mie_global_i,
   output logic       any_irq_o,
   output logic [3:0] code_o
);

   logic en_ext, en_sft, en_tmr;

   assign en_ext = ext_i & meie_i & mie_global_i;
   assign en_sft = sft_i & msie_i & mie_global_i;
   assign en_tmr = tmr_i & mtie_i & mie_global_i;

   assign any_irq_o = en_ext | en_sft | en_tmr;

   always_comb begin
      code_o = 4'd0;
      if (en_ext) begin
         code_o = 4'(CODE_MEI);
      end else if (en_sft) begin
         code_o = 4'(CODE_MSI);
      end else if (en_tmr) begin
         code_o = 4'(CODE_MTI);
      end
   end

endmodule

// File: rtl/excp_irq_ctrl.sv
// -----------------------------------------------------------------------------
// excp_irq_ctrl
// Machine-mode interrupt trap / MRET controller. Takes enabled interrupts at a
// commit boundary, issues the trap CSR update pulse, then a redirect to the
// trap vector. Also services MRET (mstatus restore pulse + redirect to mepc).
//
// Optional build macro: EXCP_VECTORED_MTVEC_EN
//   defined   : mtvec mode 01 targets base + 4*code for interrupts
//   undefined : mtvec[1:0] ignored, always direct mode
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   irq_i_ext/sft/tmr             synchronized interrupt indicators
//   csr_i_mie_global, csr_i_mpie  mstatus.MIE / mstatus.MPIE
//   csr_i_meie/msie/mtie          mie enable bits
//   csr_i_mtvec, csr_i_mepc       trap vector base / MRET target
//   cmt_i_*                       commit boundary information
//   ifu_i_redir_ready             IFU accepts redirect
//   ifu_o_redir_valid/pc          redirect request to IFU
//   cmt_o_stall                   block further commits
//   csr_o_trap_we, csr_o_mepc, csr_o_mcause   trap CSR update pulse + data
//   csr_o_mret_we                 MRET mstatus restore pulse
//   irq_o_taken                   pulse when a trap redirect is accepted
//   dbg_o_state                   current FSM state (observation only)
//
// Redirect handshake: ifu_o_redir_valid rises and, together with
// ifu_o_redir_pc, is held stable until the cycle ifu_i_redir_ready is high;
// the transfer completes in that cycle and valid drops the next cycle.
// -----------------------------------------------------------------------------
module excp_irq_ctrl
   import excp_irq_ctrl_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned PC_SIZE    = 32,
   parameter int unsigned MCAUSE_MEI = CAUSE_MEI,
   parameter int unsigned MCAUSE_MSI = CAUSE_MSI,
   parameter int unsigned MCAUSE_MTI = CAUSE_MTI
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               irq_i_ext,
   input  logic               irq_i_sft,
   input  logic               irq_i_tmr,
   input  logic               csr_i_mie_global,
   input  logic               csr_i_mpie,
   input  logic               csr_i_meie,
   input  logic               csr_i_msie,
   input  logic               csr_i_mtie,
   input  logic [XLEN-1:0]    csr_i_mtvec,
   input  logic [XLEN-1:0]    csr_i_mepc,
   input  logic               cmt_i_valid,
   input  logic [PC_SIZE-1:0] cmt_i_npc,
   input  logic               cmt_i_mret,
   input  logic               cmt_i_bjp_flush,
   input  logic               ifu_i_redir_ready,
   output logic               ifu_o_redir_valid,
   output logic [PC_SIZE-1:0] ifu_o_redir_pc,
   output logic               cmt_o_stall,
   output logic               csr_o_trap_we,
   output logic               csr_o_mret_we,
   output logic [XLEN-1:0]    csr_o_mepc,
   output logic [XLEN-1:0]    csr_o_mcause,
   output logic               irq_o_taken,
   output excp_state_e        dbg_o_state
);

   excp_state_e        state_q, state_d;
   logic [XLEN-1:0]    cause_q, cause_d;
   logic [XLEN-1:0]    mepc_q,  mepc_d;
   logic [PC_SIZE-1:0] tgt_q,   tgt_d;

   logic               any_irq;
   logic [3:0]         irq_code;
   logic               trap_acc;
   logic               mret_acc;
   logic [XLEN-1:0]    mtvec_base;
   logic [XLEN-1:0]    trap_tgt;

   excp_irq_ctrl_irq_prio_enc #(
      .CODE_MEI (MCAUSE_MEI),
      .CODE_MSI (MCAUSE_MSI),
      .CODE_MTI (MCAUSE_MTI)
   ) u_prio_enc (
      .ext_i        (irq_i_ext),
      .sft_i        (irq_i_sft),
      .tmr_i        (irq_i_tmr),
      .meie_i       (csr_i_meie),
      .msie_i       (csr_i_msie),
      .mtie_i       (csr_i_mtie),
      .mie_global_i (csr_i_mie_global),
      .any_irq_o    (any_irq),
      .code_o       (irq_code)
   );

   assign mtvec_base = {csr_i_mtvec[XLEN-1:2], 2'b00};

`ifdef EXCP_VECTORED_MTVEC_EN
   always_comb begin
      trap_tgt = mtvec_base;
      if (csr_i_mtvec[1:0] == MTVEC_MODE_VECTORED) begin
         trap_tgt = mtvec_base + XLEN'({irq_code, 2'b00});
      end
   end
   // MPIE is restored by the CSR file itself on csr_o_mret_we.
   logic unused_ok;
   assign unused_ok = csr_i_mpie;
`else
   assign trap_tgt = mtvec_base;
   // Mode bits are meaningless in direct-only builds; MPIE is handled by the CSR file.
   logic unused_ok;
   assign unused_ok = ^{csr_i_mpie, csr_i_mtvec[1:0]};
`endif

   // Accept decisions are qualified with rst_n so the combinational IDLE
   // outputs (stall, mret_we) are also 0 while reset is asserted.
   assign trap_acc = rst_n & any_irq & cmt_i_valid & ~cmt_i_bjp_flush;
   assign mret_acc = rst_n & cmt_i_valid & cmt_i_mret & ~trap_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cause_q <= '0;
         mepc_q  <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         mepc_q  <= mepc_d;
         tgt_q   <= tgt_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      cause_d           = cause_q;
      mepc_d            = mepc_q;
      tgt_d             = tgt_q;
      ifu_o_redir_valid = 1'b0;
      ifu_o_redir_pc    = '0;
      cmt_o_stall       = 1'b0;
      csr_o_trap_we     = 1'b0;
      csr_o_mret_we     = 1'b0;
      csr_o_mepc        = '0;
      csr_o_mcause      = '0;
      irq_o_taken       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (trap_acc) begin
               // Cause, epc and vector target are all frozen here so later
               // irq/CSR changes cannot disturb the trap in flight.
               cause_d     = {1'b1, (XLEN-1)'(irq_code)};
               mepc_d      = XLEN'(cmt_i_npc);
               tgt_d       = PC_SIZE'(trap_tgt);
               cmt_o_stall = 1'b1;
               state_d     = ST_TRAP_CSR;
            end else if (mret_acc) begin
               tgt_d         = PC_SIZE'(csr_i_mepc);
               cmt_o_stall   = 1'b1;
               csr_o_mret_we = 1'b1;
               state_d       = ST_MRET_REDIR;
            end
         end
         ST_TRAP_CSR: begin
            cmt_o_stall   = 1'b1;
            csr_o_trap_we = 1'b1;
            csr_o_mepc    = mepc_q;
            csr_o_mcause  = cause_q;
            state_d       = ST_REDIR;
         end
         ST_REDIR: begin
            cmt_o_stall       = 1'b1;
            ifu_o_redir_valid = 1'b1;
            ifu_o_redir_pc    = tgt_q;
            if (ifu_i_redir_ready) begin
               irq_o_taken = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_MRET_REDIR: begin
            cmt_o_stall       = 1'b1;
            ifu_o_redir_valid = 1'b1;
            ifu_o_redir_pc    = tgt_q;
            if (ifu_i_redir_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign dbg_o_state = state_q;

endmodule
